// File: rtl/si5340_i2c_responder.sv
// I2C target modelling the Si5340 register interface: 7-bit device address,
// 16-bit auto-incrementing register pointer, local register file, write strobe.
module si5340_i2c_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h74,
    parameter int         MEM_DEPTH  = 4096,
    parameter int         HOLD_CYC   = 4
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        scl_pad_i,
    input  logic        sda_pad_i,
    output logic        sda_pad_o,
    output logic        sda_padoen_o,
    output logic        busy_o,
    output logic        wr_stb_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int HC_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLD_CYC - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_HI, ST_ACK_HI, ST_REG_LO,
        ST_ACK_LO, ST_WR_DATA, ST_ACK_WR, ST_RD_DATA, ST_RD_ACK
    } state_t;

    state_t          state_q;
    logic            scl_s1_q, scl_s2_q, scl_d_q;
    logic            sda_s1_q, sda_s2_q, sda_d_q;
    logic [2:0]      bit_cnt_q;
    logic            byte_done_q, rw_q, mack_q;
    logic [7:0]      sh_q;
    logic [15:0]     ptr_q;
    logic [HC_W-1:0] hold_cnt_q;
    logic            hold_pend_q, drive_val_q;
    logic            sda_oen_q, busy_q, wr_stb_q;
    logic [15:0]     wr_addr_q;
    logic [7:0]      wr_data_q;
    logic [7:0]      mem_q [MEM_DEPTH] = '{default: 8'h00};

    logic       scl_rise, scl_fall, start_det, stop_det, last_bit, wr_fire;
    logic [7:0] byte_in, rd_byte;

    assign scl_rise  = scl_s2_q & ~scl_d_q;
    assign scl_fall  = ~scl_s2_q & scl_d_q;
    assign start_det = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
    assign byte_in   = {sh_q[6:0], sda_s2_q};
    assign rd_byte   = mem_q[ptr_q[IDX_W-1:0]];
    assign last_bit  = scl_rise & (bit_cnt_q == 3'd7);
    assign wr_fire   = arstn_i & last_bit & (state_q == ST_WR_DATA) & ~start_det & ~stop_det;

    // NOTE: the register file has no reset; it keeps its contents across arstn_i.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[ptr_q[IDX_W-1:0]] <= byte_in;
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q     <= ST_IDLE;
            scl_s1_q    <= 1'b1; scl_s2_q <= 1'b1; scl_d_q <= 1'b1;
            sda_s1_q    <= 1'b1; sda_s2_q <= 1'b1; sda_d_q <= 1'b1;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b1;
            sh_q        <= 8'h00;
            ptr_q       <= 16'h0000;
            hold_cnt_q  <= '0;
            hold_pend_q <= 1'b0;
            drive_val_q <= 1'b1;
            sda_oen_q   <= 1'b1;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 8'h00;
        end else begin
            scl_s1_q <= scl_pad_i; scl_s2_q <= scl_s1_q; scl_d_q <= scl_s2_q;
            sda_s1_q <= sda_pad_i; sda_s2_q <= sda_s1_q; sda_d_q <= sda_s2_q;
            wr_stb_q <= 1'b0;

            if (start_det || stop_det) begin
                state_q     <= start_det ? ST_DEV_ADDR : ST_IDLE;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                hold_pend_q <= 1'b0;
                sda_oen_q   <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                // Deferred SDA update: lands HOLD_CYC cycles after the detected SCL fall.
                if (hold_pend_q) begin
                    if (hold_cnt_q == '0) begin
                        hold_pend_q <= 1'b0;
                        sda_oen_q   <= drive_val_q;
                        if (state_q == ST_DEV_ACK && !drive_val_q) busy_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HC_W'(1);
                    end
                end

                if (scl_rise) begin
                    case (state_q)
                        ST_DEV_ADDR, ST_REG_HI, ST_REG_LO, ST_WR_DATA: begin
                            sh_q      <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) byte_done_q <= 1'b1;
                            if (last_bit && state_q == ST_DEV_ADDR) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    rw_q <= byte_in[0];
                                end else begin
                                    state_q     <= ST_IDLE;
                                    byte_done_q <= 1'b0;
                                end
                            end
                            if (last_bit && state_q == ST_REG_HI) ptr_q[15:8] <= byte_in;
                            if (last_bit && state_q == ST_REG_LO) ptr_q[7:0]  <= byte_in;
                            if (wr_fire) begin
                                wr_stb_q  <= 1'b1;
                                wr_addr_q <= ptr_q;
                                wr_data_q <= byte_in;
                                ptr_q     <= ptr_q + 16'd1;
                            end
                        end
                        ST_RD_DATA: begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                byte_done_q <= 1'b1;
                                ptr_q       <= ptr_q + 16'd1;
                            end
                        end
                        ST_RD_ACK: mack_q <= sda_s2_q;
                        default: ;
                    endcase
                end

                // Byte states move to their ACK state on the 8th fall; ACK states leave on the 9th.
                if (scl_fall) begin
                    hold_pend_q <= 1'b1;
                    hold_cnt_q  <= HC_LOAD;
                    drive_val_q <= 1'b1;
                    case (state_q)
                        ST_DEV_ADDR: if (byte_done_q) begin state_q <= ST_DEV_ACK; drive_val_q <= 1'b0; byte_done_q <= 1'b0; end
                        ST_REG_HI:   if (byte_done_q) begin state_q <= ST_ACK_HI;  drive_val_q <= 1'b0; byte_done_q <= 1'b0; end
                        ST_REG_LO:   if (byte_done_q) begin state_q <= ST_ACK_LO;  drive_val_q <= 1'b0; byte_done_q <= 1'b0; end
                        ST_WR_DATA:  if (byte_done_q) begin state_q <= ST_ACK_WR;  drive_val_q <= 1'b0; byte_done_q <= 1'b0; end
                        ST_RD_DATA: begin
                            if (byte_done_q) begin
                                state_q     <= ST_RD_ACK;
                                byte_done_q <= 1'b0;
                            end else begin
                                drive_val_q <= sh_q[7];
                                sh_q        <= {sh_q[6:0], 1'b0};
                            end
                        end
                        ST_ACK_HI: state_q <= ST_REG_LO;
                        ST_ACK_LO, ST_ACK_WR: state_q <= ST_WR_DATA;
                        ST_DEV_ACK, ST_RD_ACK: begin
                            if ((state_q == ST_DEV_ACK) ? rw_q : !mack_q) begin
                                state_q     <= ST_RD_DATA;
                                drive_val_q <= rd_byte[7];
                                sh_q        <= {rd_byte[6:0], 1'b0};
                            end else begin
                                state_q <= (state_q == ST_DEV_ACK) ? ST_REG_HI : ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen_q;
    assign busy_o       = busy_q;
    assign wr_stb_o     = wr_stb_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
endmodule

// File: tb/tb_si5340_i2c_responder.sv
// Bench for si5340_i2c_responder: bit-level I2C master, transaction-level
// register-file model, strobe scoreboard and SDA hold-latency monitor.
module tb_si5340_i2c_responder;
  localparam int         HOLD_CYC = 4;
  localparam int         Q        = 6;
  localparam logic [6:0] SLA      = 7'h74;
  localparam int         LAT      = 3 + HOLD_CYC;

  logic        clk = 1'b0, arstn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_pad_o, sda_padoen_o, busy_o, wr_stb_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;

  int n_checks = 0, n_errors = 0;

  logic [7:0]  m_mem [4096];
  logic [15:0] m_ptr = 16'h0000;
  logic [7:0]  wq [$];
  logic [23:0] exp_stb [$];
  logic [23:0] got_stb [$];
  int          lat_q [$];
  int          since_fall = 0, stb_run = 0, max_run = 0;
  logic        scl_prev = 1'b1, oen_prev = 1'b1;

  assign sda_bus = sda_m & (sda_padoen_o ? 1'b1 : sda_pad_o);

  si5340_i2c_responder #(.SLAVE_ADDR(SLA), .MEM_DEPTH(4096), .HOLD_CYC(HOLD_CYC)) dut (
    .clk_i(clk), .arstn_i(arstn), .scl_pad_i(scl_m), .sda_pad_i(sda_bus),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .busy_o(busy_o),
    .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Observers sample 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (scl_prev && !scl_m) since_fall = 1; else since_fall++;
    if (sda_padoen_o !== oen_prev && !scl_m && arstn) lat_q.push_back(since_fall);
    scl_prev = scl_m;
    oen_prev = sda_padoen_o;
    if (wr_stb_o) begin
      got_stb.push_back({wr_addr_o, wr_data_o});
      stb_run++;
      if (stb_run > max_run) max_run = stb_run;
    end else begin
      stb_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---- master primitives ----
  task automatic bit_xfer(input logic b, output logic smp);
    sda_m = b;   tick(Q);
    scl_m = 1'b1; tick(Q);
    smp = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  // ---- reference model ----
  task automatic m_write(input logic [7:0] b);
    m_mem[m_ptr[11:0]] = b;
    exp_stb.push_back({m_ptr, b});
    m_ptr = m_ptr + 16'd1;
  endtask

  task automatic m_read(output logic [7:0] b);
    b = m_mem[m_ptr[11:0]];
    m_ptr = m_ptr + 16'd1;
  endtask

  task automatic check_strobes();
    check("stb_count", got_stb.size(), exp_stb.size());
    for (int i = 0; i < exp_stb.size() && i < got_stb.size(); i++)
      check("stb_addr_data", got_stb[i], exp_stb[i]);
    got_stb.delete();
    exp_stb.delete();
  endtask

  task automatic check_lat();
    if (lat_q.size() > 0) begin
      int v = lat_q[0];
      foreach (lat_q[i]) if (lat_q[i] != LAT) v = lat_q[i];
      check("sda_hold_latency", v, LAT);
    end
    lat_q.delete();
  endtask

  task automatic send_ptr(input logic [15:0] p);
    logic ack;
    write_byte({SLA, 1'b0}, ack); check("sla_w_ack", ack, 0);
    check("busy_after_sla", busy_o, 1);
    write_byte(p[15:8], ack);     check("ptr_hi_ack", ack, 0);
    write_byte(p[7:0], ack);      check("ptr_lo_ack", ack, 0);
    m_ptr = p;
  endtask

  // ---- transactions ----
  task automatic tx_write(input logic [15:0] p);
    logic ack;
    i2c_start();
    send_ptr(p);
    foreach (wq[i]) begin
      write_byte(wq[i], ack);
      check("data_ack", ack, 0);
      m_write(wq[i]);
    end
    i2c_stop();
    check("busy_after_stop", busy_o, 0);
    check_strobes();
    check_lat();
  endtask

  task automatic tx_read(input int n, input bit set_ptr, input logic [15:0] p);
    logic       ack;
    logic [7:0] d, e;
    i2c_start();
    if (set_ptr) begin
      send_ptr(p);
      i2c_start();
    end
    write_byte({SLA, 1'b1}, ack);
    check("sla_r_ack", ack, 0);
    check("busy_after_sla_r", busy_o, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(d, k == n - 1);
      m_read(e);
      check("rd_data", d, e);
    end
    check("rd_nack_release", sda_padoen_o, 1);
    i2c_stop();
    check("busy_after_rd_stop", busy_o, 0);
    check_strobes();
    check_lat();
  endtask

  task automatic tx_bad_addr(input logic [6:0] dev);
    logic ack;
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    check("bad_sla_nack", ack, 1);
    check("bad_sla_busy", busy_o, 0);
    write_byte(8'($urandom), ack);
    check("bad_sla_silent", ack, 1);
    check("bad_sla_busy2", busy_o, 0);
    i2c_stop();
    check_strobes();
    check_lat();
  endtask

  initial begin
    logic       ack, s;
    logic [6:0] dev;
    logic [15:0] p;
    int kind, n;

    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;

    tick(4);
    check("rst_oen", sda_padoen_o, 1);
    check("rst_pad_o", sda_pad_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_stb", wr_stb_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    arstn = 1'b1;
    tick(4);

    // Single write, random read back, pointer-only write, current-address read.
    wq = '{8'h5A};
    tx_write(16'h0B24);
    tx_read(1, 1'b1, 16'h0B24);
    wq = '{};
    tx_write(16'h0B24);
    tx_read(1, 1'b0, 16'h0000);

    // Burst across a byte boundary, then read back with ACK, ACK, NACK.
    wq = '{8'h11, 8'h22, 8'h33};
    tx_write(16'h00FE);
    tx_read(3, 1'b1, 16'h00FE);

    tx_bad_addr(7'h75);

    // Pointer wrap.
    wq = '{8'hA5, 8'hC3};
    tx_write(16'hFFFF);
    tx_read(2, 1'b1, 16'hFFFF);

    // Reset while the target is driving a 0 data bit.
    wq = '{8'h3C};
    tx_write(16'h0200);
    i2c_start();
    send_ptr(16'h0200);
    i2c_start();
    write_byte({SLA, 1'b1}, ack);
    check("rst_test_sla_ack", ack, 0);
    tick(2);
    check("rd_drive0", sda_padoen_o, 0);
    arstn = 1'b0;
    tick(1);
    check("mid_rst_release", sda_padoen_o, 1);
    check("mid_rst_busy", busy_o, 0);
    arstn = 1'b1;
    m_ptr = 16'h0000;
    tick(Q);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(2 * Q);
    lat_q.delete();
    got_stb.delete();
    tx_read(1, 1'b0, 16'h0000);
    wq = '{8'h77};
    tx_write(16'h0300);

    // Randomized traffic against the model.
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 3);
      p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0400 + 16'($urandom_range(0, 15));
      case (kind)
        0: begin
          n = $urandom_range(0, 3);
          wq = '{};
          for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
          tx_write(p);
        end
        1: tx_read($urandom_range(1, 3), 1'b0, 16'h0000);
        2: tx_read($urandom_range(1, 3), 1'b1, p);
        default: begin
          dev = 7'($urandom);
          if (dev == SLA) dev = dev ^ 7'h01;
          tx_bad_addr(dev);
        end
      endcase
    end

    check("stb_width", max_run, 1);
    s = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
